// File: rtl/rect_fill_if.sv
// Request / pixel-output bundle for the rectangle filler.
// The master side issues draw requests and consumes pixels; the slave side is the filler.
interface rect_fill_if #(
   parameter int X_W    = 8,
   parameter int Y_W    = 7,
   parameter int SIZE_W = 5,
   parameter int COL_W  = 3
) ();
   logic              start;
   logic [X_W-1:0]    x0;
   logic [Y_W-1:0]    y0;
   logic [SIZE_W-1:0] w;
   logic [SIZE_W-1:0] h;
   logic [COL_W-1:0]  colour_in;
   logic [1:0]        mode;
   logic              hold;
   logic [X_W-1:0]    x;
   logic [Y_W-1:0]    y;
   logic [COL_W-1:0]  colour;
   logic              plot;
   logic              busy;
   logic              done;

   modport master (
      output start, x0, y0, w, h, colour_in, mode, hold,
      input  x, y, colour, plot, busy, done
   );

   modport slave (
      input  start, x0, y0, w, h, colour_in, mode, hold,
      output x, y, colour, plot, busy, done
   );
endinterface

// File: rtl/rect_fill.sv
// Rectangle filler: scans a w x h box row-major from (x0,y0), one pixel per un-stalled
// cycle, emitting solid, outline or clear pixels; coordinates wrap with no clipping.
module rect_fill #(
   parameter int X_W    = 8,
   parameter int Y_W    = 7,
   parameter int SIZE_W = 5,
   parameter int COL_W  = 3
) (
   input  logic        clk,
   input  logic        reset,
   rect_fill_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

   state_t            state_q, state_d;
   logic [X_W-1:0]    x0_q, x0_d;
   logic [Y_W-1:0]    y0_q, y0_d;
   logic [SIZE_W-1:0] w_q, w_d;
   logic [SIZE_W-1:0] h_q, h_d;
   logic [COL_W-1:0]  col_q, col_d;
   logic [1:0]        mode_q, mode_d;
   logic [SIZE_W-1:0] cx_q, cx_d;
   logic [SIZE_W-1:0] cy_q, cy_d;
   logic [X_W-1:0]    x_q, x_d;
   logic [Y_W-1:0]    y_q, y_d;
   logic [COL_W-1:0]  colour_q, colour_d;
   logic              plot_q, plot_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic [SIZE_W-1:0] w_m1;
   logic [SIZE_W-1:0] h_m1;
   logic              row_end;
   logic              last_px;
   logic              on_edge;
   logic              step;

   assign w_m1    = w_q - SIZE_W'(1);
   assign h_m1    = h_q - SIZE_W'(1);
   assign row_end = (cx_q == w_m1);
   assign last_px = row_end && (cy_q == h_m1);
   assign on_edge = (cx_q == '0) || row_end || (cy_q == '0) || (cy_q == h_m1);
   assign step    = (state_q == DRAW) && !bus.hold;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = (bus.w != '0 && bus.h != '0) ? DRAW : DONE;
            end
         end
         DRAW: begin
            if (step && last_px) begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Operand latch and scan counters.
   always_comb begin
      x0_d   = x0_q;
      y0_d   = y0_q;
      w_d    = w_q;
      h_d    = h_q;
      col_d  = col_q;
      mode_d = mode_q;
      cx_d   = cx_q;
      cy_d   = cy_q;
      if (state_q == IDLE && bus.start) begin
         x0_d   = bus.x0;
         y0_d   = bus.y0;
         w_d    = bus.w;
         h_d    = bus.h;
         col_d  = bus.colour_in;
         mode_d = bus.mode;
         cx_d   = '0;
         cy_d   = '0;
      end else if (step) begin
         if (last_px) begin
            cx_d = '0;
            cy_d = '0;
         end else if (row_end) begin
            cx_d = '0;
            cy_d = cy_q + SIZE_W'(1);
         end else begin
            cx_d = cx_q + SIZE_W'(1);
         end
      end
   end

   // Pixel outputs; x/y/colour keep their last value whenever nothing is presented.
   always_comb begin
      x_d      = x_q;
      y_d      = y_q;
      colour_d = colour_q;
      plot_d   = 1'b0;
      busy_d   = (state_d == DRAW);
      done_d   = (state_q == DONE);
      if (step) begin
         x_d      = x0_q + X_W'(cx_q);
         y_d      = y0_q + Y_W'(cy_q);
         colour_d = (mode_q == 2'b10) ? '0 : col_q;
         plot_d   = (mode_q == 2'b01) ? on_edge : 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         x0_q     <= '0;
         y0_q     <= '0;
         w_q      <= '0;
         h_q      <= '0;
         col_q    <= '0;
         mode_q   <= '0;
         cx_q     <= '0;
         cy_q     <= '0;
         x_q      <= '0;
         y_q      <= '0;
         colour_q <= '0;
         plot_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         x0_q     <= x0_d;
         y0_q     <= y0_d;
         w_q      <= w_d;
         h_q      <= h_d;
         col_q    <= col_d;
         mode_q   <= mode_d;
         cx_q     <= cx_d;
         cy_q     <= cy_d;
         x_q      <= x_d;
         y_q      <= y_d;
         colour_q <= colour_d;
         plot_q   <= plot_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign bus.x      = x_q;
   assign bus.y      = y_q;
   assign bus.colour = colour_q;
   assign bus.plot   = plot_q;
   assign bus.busy   = busy_q;
   assign bus.done   = done_q;

endmodule

// File: tb/tb_rect_fill.sv
// Randomized bench for rect_fill: each draw is predicted from the rectangle itself
// (pixel index -> column/row -> wrapped coordinate) and compared cycle by cycle.
module tb_rect_fill;

   localparam int X_W    = 8;
   localparam int Y_W    = 7;
   localparam int SIZE_W = 5;
   localparam int COL_W  = 3;

   logic clk = 1'b0;
   logic reset;
   int   checks   = 0;
   int   failures = 0;

   rect_fill_if #(.X_W(X_W), .Y_W(Y_W), .SIZE_W(SIZE_W), .COL_W(COL_W)) bus ();

   rect_fill #(.X_W(X_W), .Y_W(Y_W), .SIZE_W(SIZE_W), .COL_W(COL_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic scramble_inputs();
      bus.x0        = X_W'($urandom);
      bus.y0        = Y_W'($urandom);
      bus.w         = SIZE_W'($urandom);
      bus.h         = SIZE_W'($urandom);
      bus.colour_in = COL_W'($urandom);
      bus.mode      = 2'($urandom);
   endtask

   // hold_mode: 0 never stall, 1 random stalls, 2 three stalls after the second pixel.
   // abort_at: nonzero -> reset once that many pixels have been presented.
   task automatic run_draw(input int x0, input int y0, input int w, input int h,
                           input int col, input int md, input int hold_mode,
                           input int abort_at, input int exp_plots);
      int   k, total, holds, cyc, nplot, hold_cnt, limit;
      int   cx, cy, ex, ey, ec, ep, last_x, last_y;
      logic hv;
      bus.x0        = X_W'(x0);
      bus.y0        = Y_W'(y0);
      bus.w         = SIZE_W'(w);
      bus.h         = SIZE_W'(h);
      bus.colour_in = COL_W'(col);
      bus.mode      = 2'(md);
      bus.hold      = 1'b0;
      bus.start     = 1'b1;
      tick();
      bus.start = 1'b0;
      $display("draw x0=%0d y0=%0d w=%0d h=%0d col=%0d mode=%0d hold_mode=%0d abort=%0d",
               x0, y0, w, h, col, md, hold_mode, abort_at);
      if (w == 0 || h == 0) begin
         chk("empty_busy", 32'(bus.busy), 0);
         chk("empty_plot0", 32'(bus.plot), 0);
         tick();
         chk("empty_done", 32'(bus.done), 1);
         chk("empty_plot1", 32'(bus.plot), 0);
         chk("empty_busy1", 32'(bus.busy), 0);
         tick();
         chk("empty_done_end", 32'(bus.done), 0);
         return;
      end
      chk("accept_busy", 32'(bus.busy), 1);
      chk("accept_plot", 32'(bus.plot), 0);
      total    = w * h;
      limit    = 4 * total + 50;
      ec       = (md == 2) ? 0 : col;
      k        = 0;
      holds    = 0;
      cyc      = 0;
      nplot    = 0;
      hold_cnt = 0;
      last_x   = 0;
      last_y   = 0;
      while (k < total) begin
         if (cyc > limit) begin
            chk("draw_timeout", 32'(cyc), 32'(limit));
            return;
         end
         case (hold_mode)
            1:       hv = ($urandom_range(0, 3) == 0);
            2:       hv = (k == 2 && hold_cnt < 3);
            default: hv = 1'b0;
         endcase
         bus.hold = hv;
         scramble_inputs();
         bus.start = 1'($urandom_range(0, 1));
         if (abort_at != 0 && k == abort_at) begin
            reset     = 1'b1;
            bus.start = 1'b1;
            tick();
            reset     = 1'b0;
            bus.start = 1'b0;
            bus.hold  = 1'b0;
            chk("abort_x", 32'(bus.x), 0);
            chk("abort_y", 32'(bus.y), 0);
            chk("abort_colour", 32'(bus.colour), 0);
            chk("abort_plot", 32'(bus.plot), 0);
            chk("abort_busy", 32'(bus.busy), 0);
            chk("abort_done", 32'(bus.done), 0);
            tick();
            chk("abort_done_next", 32'(bus.done), 0);
            chk("abort_busy_next", 32'(bus.busy), 0);
            chk("abort_plot_next", 32'(bus.plot), 0);
            return;
         end
         tick();
         cyc++;
         if (hv) begin
            holds++;
            hold_cnt++;
            chk("hold_plot", 32'(bus.plot), 0);
            chk("hold_busy", 32'(bus.busy), 1);
            if (k > 0) begin
               chk("hold_x", 32'(bus.x), 32'(last_x));
               chk("hold_y", 32'(bus.y), 32'(last_y));
            end
         end else begin
            cx = k % w;
            cy = k / w;
            ex = (x0 + cx) % (1 << X_W);
            ey = (y0 + cy) % (1 << Y_W);
            ep = (md == 1) ? int'(cx == 0 || cx == w - 1 || cy == 0 || cy == h - 1) : 1;
            chk("pix_plot", 32'(bus.plot), 32'(ep));
            chk("pix_x", 32'(bus.x), 32'(ex));
            chk("pix_y", 32'(bus.y), 32'(ey));
            chk("pix_colour", 32'(bus.colour), 32'(ec));
            nplot += ep;
            last_x = ex;
            last_y = ey;
            k++;
            chk("pix_busy", 32'(bus.busy), 32'(k < total));
         end
         chk("draw_no_done", 32'(bus.done), 0);
      end
      bus.hold = 1'($urandom_range(0, 1));
      tick();
      cyc++;
      chk("done_pulse", 32'(bus.done), 1);
      chk("done_latency", 32'(cyc), 32'(total + holds + 1));
      chk("done_plot", 32'(bus.plot), 0);
      chk("done_busy", 32'(bus.busy), 0);
      bus.start = 1'b0;
      bus.hold  = 1'b0;
      tick();
      chk("done_end", 32'(bus.done), 0);
      if (exp_plots >= 0) begin
         chk("plot_count", 32'(nplot), 32'(exp_plots));
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset         = 1'b1;
      bus.start     = 1'b0;
      bus.hold      = 1'b0;
      bus.x0        = '0;
      bus.y0        = '0;
      bus.w         = '0;
      bus.h         = '0;
      bus.colour_in = '0;
      bus.mode      = '0;
      tick();
      tick();
      chk("rst_x", 32'(bus.x), 0);
      chk("rst_y", 32'(bus.y), 0);
      chk("rst_colour", 32'(bus.colour), 0);
      chk("rst_plot", 32'(bus.plot), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_done", 32'(bus.done), 0);

      // Reset wins over a simultaneous start.
      bus.w     = SIZE_W'(3);
      bus.h     = SIZE_W'(3);
      bus.start = 1'b1;
      tick();
      chk("rst_vs_start_busy", 32'(bus.busy), 0);
      reset     = 1'b0;
      bus.start = 1'b0;
      tick();
      chk("rst_vs_start_busy2", 32'(bus.busy), 0);
      chk("rst_vs_start_done", 32'(bus.done), 0);

      run_draw(10, 20, 16, 16, 5, 0, 0, 0, 256);
      run_draw(0, 0, 4, 3, 6, 1, 0, 0, 10);
      run_draw(254, 0, 4, 1, 7, 2, 0, 0, 4);
      run_draw(5, 5, 0, 5, 2, 0, 0, 0, -1);
      run_draw(1, 2, 2, 2, 3, 0, 2, 0, 4);
      run_draw(10, 20, 16, 16, 5, 0, 0, 5, -1);
      run_draw(100, 120, 3, 2, 4, 3, 0, 0, 6);

      for (int i = 0; i < 40; i++) begin
         run_draw(int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
                  int'($urandom_range(0, 9)), int'($urandom_range(0, 9)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                  1, 0, -1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
